// File: rtl/kara27_pp_gen.sv
// 3-way Karatsuba partial-product generator: six carry-less limb products on one shared multiplier.
// Build option KARA_SERIAL_MUL_EN: shared multiplier becomes bit-serial (9 clocks per product).
module kara27_pp_gen #(
    parameter int LIMB_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*LIMB_W-1:0]   a,
    input  logic [3*LIMB_W-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*LIMB_W-2:0]   p0,
    output logic [2*LIMB_W-2:0]   p1,
    output logic [2*LIMB_W-2:0]   p2,
    output logic [2*LIMB_W-2:0]   p3,
    output logic [2*LIMB_W-2:0]   p4,
    output logic [2*LIMB_W-2:0]   p5
);

    localparam int PW = 2*LIMB_W-1;
    localparam int OW = 3*LIMB_W;
    localparam int BW = $clog2(LIMB_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [2:0]        r_step;
    logic [OW-1:0]     r_a;
    logic [OW-1:0]     r_b;
    logic [OW-1:0]     r_sa;
    logic [OW-1:0]     r_sb;
    logic [PW-1:0]     r_p0, r_p1, r_p2, r_p3, r_p4, r_p5;

    logic [LIMB_W-1:0] w_x;
    logic [LIMB_W-1:0] w_y;
    logic [PW-1:0]     w_prod;
    logic              w_prod_done;
    logic [OW-1:0]     w_sa;
    logic [OW-1:0]     w_sb;

    // Limb sums packed as {a1^a2, a0^a2, a0^a1} so steps 2,4,5 index them in order
    assign w_sa = {a[2*LIMB_W-1:LIMB_W] ^ a[3*LIMB_W-1:2*LIMB_W],
                   a[LIMB_W-1:0]        ^ a[3*LIMB_W-1:2*LIMB_W],
                   a[LIMB_W-1:0]        ^ a[2*LIMB_W-1:LIMB_W]};
    assign w_sb = {b[2*LIMB_W-1:LIMB_W] ^ b[3*LIMB_W-1:2*LIMB_W],
                   b[LIMB_W-1:0]        ^ b[3*LIMB_W-1:2*LIMB_W],
                   b[LIMB_W-1:0]        ^ b[2*LIMB_W-1:LIMB_W]};

    // Operand selection for the shared multiplier by product step
    always_comb begin
        w_x = '0;
        w_y = '0;
        case (r_step)
            3'd0: begin w_x = r_a[LIMB_W-1:0];           w_y = r_b[LIMB_W-1:0];           end
            3'd1: begin w_x = r_a[2*LIMB_W-1:LIMB_W];    w_y = r_b[2*LIMB_W-1:LIMB_W];    end
            3'd2: begin w_x = r_sa[LIMB_W-1:0];          w_y = r_sb[LIMB_W-1:0];          end
            3'd3: begin w_x = r_a[3*LIMB_W-1:2*LIMB_W];  w_y = r_b[3*LIMB_W-1:2*LIMB_W];  end
            3'd4: begin w_x = r_sa[2*LIMB_W-1:LIMB_W];   w_y = r_sb[2*LIMB_W-1:LIMB_W];   end
            3'd5: begin w_x = r_sa[3*LIMB_W-1:2*LIMB_W]; w_y = r_sb[3*LIMB_W-1:2*LIMB_W]; end
            default: begin w_x = '0; w_y = '0; end
        endcase
    end

`ifdef KARA_SERIAL_MUL_EN
    logic [BW-1:0] r_bit;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] w_acc_next;

    // One y bit per clock, LSB first; the last bit's sum is the finished product
    always_comb begin
        if (w_y[r_bit]) begin
            w_acc_next = r_acc ^ ({{(LIMB_W-1){1'b0}}, w_x} << r_bit);
        end else begin
            w_acc_next = r_acc;
        end
    end

    assign w_prod      = w_acc_next;
    assign w_prod_done = (r_bit == BW'(LIMB_W-1));
`else
    function automatic logic [PW-1:0] clmul(input logic [LIMB_W-1:0] x,
                                            input logic [LIMB_W-1:0] y);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < LIMB_W; i++) begin
            if (y[i]) begin
                acc = acc ^ ({{(LIMB_W-1){1'b0}}, x} << i);
            end
        end
        return acc;
    endfunction

    assign w_prod      = clmul(w_x, w_y);
    assign w_prod_done = 1'b1;
`endif

    // Control FSM, operand capture and product registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_step      <= 3'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_sa        <= '0;
            r_sb        <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_p3        <= '0;
            r_p4        <= '0;
            r_p5        <= '0;
`ifdef KARA_SERIAL_MUL_EN
            r_bit       <= '0;
            r_acc       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_sa       <= w_sa;
                        r_sb       <= w_sb;
                        r_step     <= 3'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_MUL;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_MUL: begin
`ifdef KARA_SERIAL_MUL_EN
                    if (w_prod_done) begin
                        r_bit <= '0;
                        r_acc <= '0;
                    end else begin
                        r_bit <= r_bit + {{(BW-1){1'b0}}, 1'b1};
                        r_acc <= w_acc_next;
                    end
`endif
                    if (w_prod_done) begin
                        case (r_step)
                            3'd0:    r_p0 <= w_prod;
                            3'd1:    r_p1 <= w_prod;
                            3'd2:    r_p2 <= w_prod;
                            3'd3:    r_p3 <= w_prod;
                            3'd4:    r_p4 <= w_prod;
                            3'd5:    r_p5 <= w_prod;
                            default: r_p0 <= r_p0;
                        endcase
                        if (r_step == 3'd5) begin
                            r_step      <= 3'd0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_step <= r_step + 3'd1;
                        end
                    end else begin
                        r_step <= r_step;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_step      <= 3'd0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p0 = r_p0;
    assign p1 = r_p1;
    assign p2 = r_p2;
    assign p3 = r_p3;
    assign p4 = r_p4;
    assign p5 = r_p5;

endmodule

// File: tb/tb_kara27_pp_gen.sv
// Scoreboard bench for kara27_pp_gen: random and directed operand pairs against a carry-less reference model.
module tb_kara27_pp_gen;

`ifdef KARA_SERIAL_MUL_EN
    localparam int LAT = 54;
`else
    localparam int LAT = 6;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] a;
    logic [26:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] p0, p1, p2, p3, p4, p5;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;
    logic [5:0][16:0] sb_q[$];

    kara27_pp_gen #(.LIMB_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: result bit i+j accumulates x[i]&y[j] by XOR
    function automatic logic [16:0] clm(input logic [8:0] x, input logic [8:0] y);
        logic [16:0] r;
        r = '0;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++)
                r[i+j] = r[i+j] ^ (x[i] & y[j]);
        return r;
    endfunction

    function automatic logic [5:0][16:0] model(input logic [26:0] ta, input logic [26:0] tb);
        logic [5:0][16:0] m;
        logic [8:0] x0, x1, x2, y0, y1, y2;
        x0 = ta[8:0]; x1 = ta[17:9]; x2 = ta[26:18];
        y0 = tb[8:0]; y1 = tb[17:9]; y2 = tb[26:18];
        m[0] = clm(x0, y0);
        m[1] = clm(x1, y1);
        m[2] = clm(x0 ^ x1, y0 ^ y1);
        m[3] = clm(x2, y2);
        m[4] = clm(x0 ^ x2, y0 ^ y2);
        m[5] = clm(x1 ^ x2, y1 ^ y2);
        return m;
    endfunction

    function automatic logic [5:0][16:0] mk(input logic [16:0] e0, e1, e2, e3, e4, e5);
        logic [5:0][16:0] m;
        m[0] = e0; m[1] = e1; m[2] = e2; m[3] = e3; m[4] = e4; m[5] = e5;
        return m;
    endfunction

    function automatic logic [5:0][16:0] outs();
        logic [5:0][16:0] m;
        m[0] = p0; m[1] = p1; m[2] = p2; m[3] = p3; m[4] = p4; m[5] = p5;
        return m;
    endfunction

    // out_ready driver: held high, held low, or random per cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every handshake pops one expected result
    initial begin
        logic [5:0][16:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", outs());
                end else begin
                    e = sb_q.pop_front();
                    chk("p0", 128'(p0), 128'(e[0]));
                    chk("p1", 128'(p1), 128'(e[1]));
                    chk("p2", 128'(p2), 128'(e[2]));
                    chk("p3", 128'(p3), 128'(e[3]));
                    chk("p4", 128'(p4), 128'(e[4]));
                    chk("p5", 128'(p5), 128'(e[5]));
                end
                chk("in_ready_while_done", 128'(in_ready), 128'(0));
            end
        end
    end

    task automatic send(input logic [26:0] ta, input logic [26:0] tb, input logic [5:0][16:0] e,
                        input bit wait_out, output time t_acc);
        int n;
        n = 0;
        t_acc = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got %0b expected 1", in_ready);
            return;
        end
        a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0;
        a = 27'($urandom);
        b = 27'($urandom);
        if (wait_out) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 200) begin
                @(posedge clk); #1; n++;
            end
            chk("latency", 128'(n), 128'(LAT));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid === 1'b1) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("drained", 128'(sb_q.size()), 128'(0));
    endtask

    initial begin
        time t1, t2;
        logic [26:0] ra, rb;
        logic [5:0][16:0] e;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_products", 128'(outs()), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 128'(in_ready), 128'(1));

        // Directed vectors with hand-derived products
        send(27'h1, 27'h1, mk(17'h1, 17'h0, 17'h1, 17'h0, 17'h1, 17'h0), 1'b1, t1);
        send(27'h7FFFFFF, 27'h7FFFFFF, mk(17'h15555, 17'h15555, 17'h0, 17'h15555, 17'h0, 17'h0), 1'b1, t1);
        send(27'h200, 27'h200, mk(17'h0, 17'h1, 17'h1, 17'h0, 17'h0, 17'h1), 1'b1, t1);
        send(27'h1FF, 27'h40001, mk(17'h1FF, 17'h0, 17'h1FF, 17'h0, 17'h0, 17'h0), 1'b1, t1);
        drain();

        // Back-to-back throughput with out_ready held high
        ra = 27'($urandom); rb = 27'($urandom);
        send(ra, rb, model(ra, rb), 1'b1, t1);
        ra = 27'($urandom); rb = 27'($urandom);
        send(ra, rb, model(ra, rb), 1'b1, t2);
        chk("throughput", 128'((t2 - t1) / 10), 128'(LAT + 2));
        drain();

        // Backpressure: outputs frozen in DONE while inputs churn
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        ra = 27'($urandom); rb = 27'($urandom);
        e = model(ra, rb);
        send(ra, rb, e, 1'b1, t1);
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 27'($urandom);
            b = 27'($urandom);
            @(posedge clk); #1;
            chk("hold_products", 128'(outs()), 128'(e));
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            chk("hold_out_valid", 128'(out_valid), 128'(1));
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Random operands with random out_ready
        rdy_mode = 2;
        for (int k = 0; k < 25; k++) begin
            case (k % 8)
                0:       begin ra = 27'h0;       rb = 27'($urandom); end
                1:       begin ra = 27'h7FFFFFF; rb = 27'($urandom); end
                default: begin ra = 27'($urandom); rb = 27'($urandom); end
            endcase
            send(ra, rb, model(ra, rb), 1'b0, t1);
        end
        rdy_mode = 0;
        drain();

        // Reset mid-operation at step 3, then a clean restart
        ra = 27'($urandom); rb = 27'($urandom);
        send(ra, rb, model(ra, rb), 1'b0, t1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(0));
        chk("abort_products", 128'(outs()), 128'(0));
        send(27'h1, 27'h1, mk(17'h1, 17'h0, 17'h1, 17'h0, 17'h1, 17'h0), 1'b1, t1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
